// File: rtl/cmos_capture_rgb565.sv
// OV5640 DVP capture: pairs camera bytes into RGB565 pixels, skips settling frames, tracks geometry.
// Optional build macro CAPTURE_TESTPAT_EN replaces pixel data with an 8-bar colour pattern.
module cmos_capture_rgb565 #(
  parameter int WAIT_FRAMES = 10,
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_start,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        cmos_frame_vsync,
  output logic        cmos_frame_href,
  output logic        cmos_frame_valid,
  output logic [15:0] cmos_frame_data,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        frame_err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_vsync_d0, r_vsync_d1;
  logic        r_href_d0, r_href_d1;
  logic [7:0]  r_data_d0;
  logic        r_phase;
  logic [7:0]  r_high;
  logic        r_valid;
  logic [15:0] r_data;
  logic [10:0] r_xpos, r_ypos;
  logic        r_err;
  logic [7:0]  r_frame_cnt;
  logic        r_stop;

  logic        w_vsync_rise, w_href_fall, w_run, w_last_skip;
  logic [11:0] w_line_pix;
  logic        w_line_bad, w_frame_bad;

  assign w_vsync_rise = r_vsync_d0 & ~r_vsync_d1;
  assign w_href_fall  = ~r_href_d0 & r_href_d1;
  assign w_run        = (r_state == ST_RUN);
  assign w_last_skip  = (r_frame_cnt == 8'(WAIT_FRAMES - 1));
  // The last pixel of a line strobes in the same cycle the href fall is seen.
  assign w_line_pix   = {1'b0, r_xpos} + {11'd0, r_valid};
  assign w_line_bad   = w_href_fall & ((w_line_pix != 12'(H_PIXELS)) | r_phase);
  assign w_frame_bad  = w_vsync_rise & (r_ypos != 11'(V_LINES));

`ifdef CAPTURE_TESTPAT_EN
  function automatic logic [15:0] bar_color(input logic [2:0] sel);
    case (sel)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (capture_start) w_next = ST_SKIP;
      ST_SKIP: begin
        if (!capture_start)                  w_next = ST_IDLE;
        else if (w_vsync_rise && w_last_skip) w_next = ST_RUN;
      end
      ST_RUN:  if (w_vsync_rise && (r_stop || !capture_start)) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmos_frame_vsync = r_vsync_d1 & w_run;
    cmos_frame_href  = r_href_d1 & w_run;
    cmos_frame_valid = r_valid;
    cmos_frame_data  = w_run ? r_data : 16'd0;
    xpos             = w_run ? r_xpos : 11'd0;
    ypos             = w_run ? r_ypos : 11'd0;
    frame_err        = r_err;
    o_dbg_state      = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d0  <= 1'b0;
      r_vsync_d1  <= 1'b0;
      r_href_d0   <= 1'b0;
      r_href_d1   <= 1'b0;
      r_data_d0   <= 8'd0;
      r_phase     <= 1'b0;
      r_high      <= 8'd0;
      r_valid     <= 1'b0;
      r_data      <= 16'd0;
      r_xpos      <= 11'd0;
      r_ypos      <= 11'd0;
      r_err       <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_stop      <= 1'b0;
    end else begin
      r_vsync_d0 <= cam_vsync;
      r_vsync_d1 <= r_vsync_d0;
      r_href_d0  <= cam_href;
      r_href_d1  <= r_href_d0;
      r_data_d0  <= cam_data;

      r_valid <= 1'b0;
      if (r_href_d0) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_high <= r_data_d0;
        end else if (w_run) begin
          r_valid <= 1'b1;
`ifdef CAPTURE_TESTPAT_EN
          r_data  <= capture_start ? bar_color(r_xpos[9:7]) : {r_high, r_data_d0};
`else
          r_data  <= {r_high, r_data_d0};
`endif
        end
      end else begin
        r_phase <= 1'b0;
      end

      if (w_href_fall)                        r_xpos <= 11'd0;
      else if (r_valid && r_xpos != 11'd2047) r_xpos <= r_xpos + 11'd1;

      if (w_vsync_rise)                           r_ypos <= 11'd0;
      else if (w_href_fall && r_ypos != 11'd2047) r_ypos <= r_ypos + 11'd1;

      r_err <= w_run & (w_line_bad | w_frame_bad);

      if (r_state != ST_SKIP)  r_frame_cnt <= 8'd0;
      else if (w_vsync_rise)   r_frame_cnt <= w_last_skip ? 8'd0 : r_frame_cnt + 8'd1;

      // A stop request in RUN is held so the frame in flight still completes.
      if (!w_run)              r_stop <= 1'b0;
      else if (!capture_start) r_stop <= 1'b1;
    end
  end

endmodule
